eps_greedy_selector: RTL
========================

// Module: eps_greedy_selector
// PURPOSE
//  Parametrised epsilon-greedy action selector for the Q-learning datapath.
//  Takes one Q-row (N_ACT signed Q values) plus the iteration count per handshake.
//  Returns either the argmax action (exploit) or a uniform random action (explore).
//  Explore probability decays linearly: (total_iteration - iteration) / total_iteration.
//  Sits between the Q-table read port and the environment/update stage.
// PARAMETERS
//  N_ACT    4        number of actions, 2..16
//  Q_W      32       Q value width, signed two's complement
//  ITER_W   12       iteration counter width
//  LFSR_W   16       PRNG width, >= ITER_W+ACT_W, 8..32
//  SEED     16'hACE1 LFSR reset value; 0 is replaced by 1
//  MAX_RETRY 7       rejection-sampling retries before forced exploit
// PORTS
//  clk             in   1            clock
//  rst_n           in   1            asynchronous reset, active low
//  in_valid        in   1            request valid
//  in_ready        out  1            selector can accept request
//  q_vec           in   N_ACT*Q_W    Q values, action i at [i*Q_W +: Q_W]
//  iteration       in   ITER_W       current iteration
//  total_iteration in   ITER_W       iteration budget
//  out_valid       out  1            result valid
//  out_ready       in   1            consumer accepts result
//  act             out  ACT_W        chosen action, ACT_W = max(1,$clog2(N_ACT))
//  explored        out  1            1 = random action, 0 = argmax
//  q_max           out  Q_W          maximum Q value of the row, both modes
// BEHAVIOUR
//  Reset: state=IDLE; lfsr=SEED; out_valid, act, explored, q_max = 0.
//  Reset mid-transaction drops that transaction. in_ready=1 in the first cycle after deassert.
//  LFSR: maximal-length Fibonacci, taps from package, steps every cycle in all states.
//  FSM:
//   IDLE: in_ready=1. in_valid -> latch q_vec/iteration/total, retry=0.
//     total==0 -> DECIDE, explore=0; else -> DRAW.
//   DRAW: r = lfsr[ITER_W-1:0].
//     r < total: explore = (r >= iteration); -> DECIDE.
//     r >= total: retry++ and stay; retry==MAX_RETRY -> explore=0, -> DECIDE.
//   DECIDE: register act, explored, q_max; -> HOLD.
//   HOLD: out_valid=1, outputs stable; out_ready -> IDLE (no same-cycle accept).
//  Latency: in accept -> out_valid = 3 cycles with no retry; +1 per retry; 2 when total==0.
//  iteration >= total never explores. iteration==0 with total>0 always explores.
//  Argmax: signed compare; ties resolve to the lowest index. Combinational tree over latched q.
//  Random action: a = lfsr[LFSR_W-1 -: ACT_W]; if a >= N_ACT then a -= N_ACT.
//   Result is always < N_ACT. Bias for non-power-of-2 N_ACT is accepted.
//  in_ready=0 outside IDLE; in_valid there is ignored.
// CONFIGURATION
//  EXPLORE_STATS_EN defined:
//   Adds port explore_cnt out ITER_W: count of completed (out handshake) explored results.
//   Saturates at all-ones; reset to 0.
//  Undefined: port and counter absent; behaviour otherwise identical.
// STRUCTURE
//  Package qlearn_pkg: state enum (IDLE, DRAW, DECIDE, HOLD), lfsr_taps(width) function,
//   and the default SEED constant.
//  Sub-module qa_argmax #(N_ACT,Q_W): combinational, outputs idx and max value.
//  LFSR and FSM stay inline.
// TESTING
//  1 total=0, q={5,-3,7,7} -> act=2, explored=0, q_max=7, out_valid 2 cycles after accept.
//  2 q all -1, iteration=total=1000, 200 txns -> every act=0, explored=0.
//  3 N_ACT=3, iteration=0, total=4095, 500 txns -> all explored=1, act in {0,1,2}.
//  4 out_ready low 10 cycles in HOLD -> act/explored stable, in_ready=0 throughout.
//  5 rst_n low during DRAW -> out_valid=0 immediately; next txn from same lfsr state repeats result.
//  6 iteration=2048, total=4096, 4000 txns -> explored fraction within 45%..55%;
//    with EXPLORE_STATS_EN, explore_cnt equals the scoreboard count.

Source files
------------

// File: rtl/qlearn_pkg.sv
// Shared types and helpers for the Q-learning datapath blocks.
// Provides the selector state encoding, the default PRNG seed and the
// tap masks for maximal-length Fibonacci LFSRs of 8 to 32 bits.
package qlearn_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DRAW   = 2'd1,
    DECIDE = 2'd2,
    HOLD   = 2'd3
  } state_e;

  localparam logic [31:0] DEFAULT_SEED = 32'h0000_ACE1;

  // Bit k of the mask set means bit k of the register feeds the XOR.
  // The register shifts toward the MSB and the feedback enters bit 0.
  function automatic logic [31:0] lfsr_taps(input int width);
    logic [31:0] taps;
    case (width)
      8:       taps = 32'h0000_00B8;
      9:       taps = 32'h0000_0110;
      10:      taps = 32'h0000_0240;
      11:      taps = 32'h0000_0500;
      12:      taps = 32'h0000_0829;
      13:      taps = 32'h0000_100D;
      14:      taps = 32'h0000_2015;
      15:      taps = 32'h0000_6000;
      16:      taps = 32'h0000_D008;
      17:      taps = 32'h0001_2000;
      18:      taps = 32'h0002_0400;
      19:      taps = 32'h0004_0023;
      20:      taps = 32'h0009_0000;
      21:      taps = 32'h0014_0000;
      22:      taps = 32'h0030_0000;
      23:      taps = 32'h0042_0000;
      24:      taps = 32'h00E1_0000;
      25:      taps = 32'h0120_0000;
      26:      taps = 32'h0200_0023;
      27:      taps = 32'h0400_0013;
      28:      taps = 32'h0900_0000;
      29:      taps = 32'h1400_0000;
      30:      taps = 32'h2000_0029;
      31:      taps = 32'h4800_0000;
      32:      taps = 32'h8020_0003;
      default: taps = 32'h0000_D008;
    endcase
    return taps;
  endfunction

endpackage

// File: rtl/qa_argmax.sv
// Combinational argmax over a packed row of signed Q values.
// Ties resolve to the lowest action index because a later entry only
// replaces the running best when it is strictly greater.
module qa_argmax #(
  parameter  int N_ACT = 4,
  parameter  int Q_W   = 32,
  localparam int ACT_W = (N_ACT > 1) ? $clog2(N_ACT) : 1
) (
  input  logic [N_ACT*Q_W-1:0] q_vec_i,
  output logic [ACT_W-1:0]     idx_o,
  output logic [Q_W-1:0]       max_o
);

  // Priority scan from action 0 upward keeping the first strict maximum.
  always_comb begin
    logic [Q_W-1:0]   best_val;
    logic [ACT_W-1:0] best_idx;
    best_val = q_vec_i[Q_W-1:0];
    best_idx = '0;
    for (int i = 1; i < N_ACT; i++) begin
      if ($signed(q_vec_i[i*Q_W +: Q_W]) > $signed(best_val)) begin
        best_val = q_vec_i[i*Q_W +: Q_W];
        best_idx = ACT_W'(i);
      end
    end
    idx_o = best_idx;
    max_o = best_val;
  end

endmodule

// File: rtl/eps_greedy_selector.sv
// Epsilon-greedy action selector: returns the argmax action of a Q row or,
// with a probability that decays linearly over the iteration budget, a
// uniformly drawn random action. Optional feature macro EXPLORE_STATS_EN
// adds a saturating count of delivered explored results on explore_cnt.
module eps_greedy_selector
  import qlearn_pkg::*;
#(
  parameter  int          N_ACT     = 4,
  parameter  int          Q_W       = 32,
  parameter  int          ITER_W    = 12,
  parameter  int          LFSR_W    = 16,
  parameter  logic [31:0] SEED      = DEFAULT_SEED,
  parameter  int          MAX_RETRY = 7,
  localparam int          ACT_W     = (N_ACT > 1) ? $clog2(N_ACT) : 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [N_ACT*Q_W-1:0]   q_vec,
  input  logic [ITER_W-1:0]      iteration,
  input  logic [ITER_W-1:0]      total_iteration,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [ACT_W-1:0]       act,
  output logic                   explored,
  output logic [Q_W-1:0]         q_max
`ifdef EXPLORE_STATS_EN
  ,
  output logic [ITER_W-1:0]      explore_cnt
`endif
);

  localparam logic [31:0]       TAPS_ALL = lfsr_taps(LFSR_W);
  localparam logic [LFSR_W-1:0] TAPS     = TAPS_ALL[LFSR_W-1:0];
  localparam logic [LFSR_W-1:0] SEED_V   = (SEED[LFSR_W-1:0] == '0) ? LFSR_W'(1) : SEED[LFSR_W-1:0];
  localparam int                RETRY_W  = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  localparam logic [ACT_W:0]    N_ACT_V  = (ACT_W + 1)'(N_ACT);

  state_e                 state_q;
  logic [LFSR_W-1:0]      lfsr_q;
  logic [LFSR_W-1:0]      lfsr_d;
  logic [N_ACT*Q_W-1:0]   q_vec_q;
  logic [ITER_W-1:0]      iter_q;
  logic [ITER_W-1:0]      total_q;
  logic [RETRY_W-1:0]     retry_q;
  logic                   explore_q;
  logic [ACT_W-1:0]       rand_q;
  logic [ITER_W-1:0]      draw;
  logic [ACT_W:0]         rand_raw;
  logic [ACT_W-1:0]       rand_act;
  logic [ACT_W-1:0]       amax_idx;
  logic [Q_W-1:0]         amax_val;

  qa_argmax #(
    .N_ACT (N_ACT),
    .Q_W   (Q_W)
  ) u_argmax (
    .q_vec_i (q_vec_q),
    .idx_o   (amax_idx),
    .max_o   (amax_val)
  );

  assign in_ready = (state_q == IDLE);

  // Next LFSR value, the explore draw from the low bits and the random action from the high bits.
  always_comb begin
    lfsr_d   = {lfsr_q[LFSR_W-2:0], ^(lfsr_q & TAPS)};
    draw     = lfsr_q[ITER_W-1:0];
    rand_raw = {1'b0, lfsr_q[LFSR_W-1 -: ACT_W]};
    rand_act = (rand_raw >= N_ACT_V) ? ACT_W'(rand_raw - N_ACT_V) : rand_raw[ACT_W-1:0];
  end

  // Free-running PRNG, stepping every cycle regardless of FSM state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr_q <= SEED_V;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  // Request latch, rejection-sampled explore decision and registered result handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      q_vec_q   <= '0;
      iter_q    <= '0;
      total_q   <= '0;
      retry_q   <= '0;
      explore_q <= 1'b0;
      rand_q    <= '0;
      out_valid <= 1'b0;
      act       <= '0;
      explored  <= 1'b0;
      q_max     <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            q_vec_q   <= q_vec;
            iter_q    <= iteration;
            total_q   <= total_iteration;
            retry_q   <= '0;
            explore_q <= 1'b0;
            state_q   <= (total_iteration == '0) ? DECIDE : DRAW;
          end
        end
        DRAW: begin
          if (draw < total_q) begin
            explore_q <= (draw >= iter_q);
            rand_q    <= rand_act;
            state_q   <= DECIDE;
          end else if (retry_q == RETRY_W'(MAX_RETRY)) begin
            explore_q <= 1'b0;
            state_q   <= DECIDE;
          end else begin
            retry_q <= retry_q + 1'b1;
          end
        end
        DECIDE: begin
          act       <= explore_q ? rand_q : amax_idx;
          explored  <= explore_q;
          q_max     <= amax_val;
          out_valid <= 1'b1;
          state_q   <= HOLD;
        end
        HOLD: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state_q   <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef EXPLORE_STATS_EN
  logic [ITER_W-1:0] explore_cnt_q;

  // Saturating count of explored results actually taken by the consumer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      explore_cnt_q <= '0;
    end else if (out_valid && out_ready && explored && (explore_cnt_q != '1)) begin
      explore_cnt_q <= explore_cnt_q + 1'b1;
    end
  end

  assign explore_cnt = explore_cnt_q;
`endif

endmodule
